inst_encoder_loader: RTL and testbench

Inverse of the pipeline's instruction classifier. It accepts one instruction class code plus its fields per handshake and encodes a 32-bit MIPS instruction word. It then writes each word sequentially into instruction memory through a write port. It is used by the bench and boot logic to load programs before the pipeline runs, and its one-hot classifier counterpart must decode every emitted word back to the same class.

---
 rtl/inst_encoder_loader.sv | 164 ++++++++++++++++
 tb/tb_inst_encoder_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader.sv
// Encodes class-coded instruction requests into 32-bit MIPS words and streams
// them into instruction memory, one write per accepted request.
module inst_encoder_loader #(
   parameter int AW    = 10,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          finish,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    cls,
   input  logic [5:0]    func,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [4:0]    shamt,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          full,
   output logic [AW:0]   count,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

   typedef struct packed {
      logic [4:0]  cls;
      logic [5:0]  func;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [25:0] target;
   } req_t;

   typedef struct packed {
      logic        illegal;
      logic [31:0] word;
   } enc_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [5:0]  FN_JR   = 6'b001000;

   state_t state, state_nxt;
   req_t   req;
   enc_t   enc;
   logic   clr, accept;

   assign req = '{cls: cls, func: func, rs: rs, rt: rt, rd: rd,
                  shamt: shamt, imm: imm, target: target};

   // Opcode of the {op, rs, rt, imm} immediate/memory classes 2..15.
   function automatic logic [5:0] itype_op(input logic [4:0] c);
      logic [5:0] op;
      op = 6'b000000;
      case (c)
         5'd2:    op = 6'b001111;
         5'd3:    op = 6'b001010;
         5'd4:    op = 6'b001101;
         5'd5:    op = 6'b001110;
         5'd6:    op = 6'b001000;
         5'd7:    op = 6'b001001;
         5'd8:    op = 6'b100011;
         5'd9:    op = 6'b101011;
         5'd10:   op = 6'b100001;
         5'd11:   op = 6'b100101;
         5'd12:   op = 6'b101001;
         5'd13:   op = 6'b100000;
         5'd14:   op = 6'b100100;
         5'd15:   op = 6'b101000;
         default: op = 6'b000000;
      endcase
      return op;
   endfunction

   function automatic enc_t encode(input req_t r);
      enc_t e;
      e.illegal = 1'b0;
      e.word    = 32'd0;
      case (r.cls)
         5'd0: begin
            // rtype carrying the jr function code would classify as jr.
            if (r.func == FN_JR) e.illegal = 1'b1;
            else e.word = {6'b000000, r.rs, r.rt, r.rd, r.shamt, r.func};
         end
         5'd1:  e.word = {6'b000000, r.rs, 15'd0, FN_JR};
         5'd2:  e.word = {itype_op(r.cls), 5'd0, r.rt, r.imm};
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
         5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
                e.word = {itype_op(r.cls), r.rs, r.rt, r.imm};
         5'd16: e.word = {6'b000100, r.rs, r.rt, r.imm};
         5'd17: e.word = {6'b000111, r.rs, 5'd0, r.imm};
         5'd18: e.word = {6'b000001, r.rs, 5'd1, r.imm};
         5'd19: e.word = {6'b000101, r.rs, r.rt, r.imm};
         5'd20: e.word = {6'b000110, r.rs, 5'd0, r.imm};
         5'd21: e.word = {6'b000010, r.target};
         5'd22: e.word = {6'b000011, r.target};
         default: e.illegal = 1'b1;
      endcase
      return e;
   endfunction

   assign enc      = encode(req);
   assign in_ready = (state == LOAD) && !finish && (count < DEPTH_C);
   assign accept   = in_valid && in_ready;
   assign busy     = (state == LOAD);
   assign full     = (count == DEPTH_C);

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               clr       = 1'b1;
            end
         end
         LOAD: begin
            if (finish) state_nxt = IDLE;
            else if (count == DEPTH_C) state_nxt = FULL;
         end
         FULL: begin
            if (finish) state_nxt = IDLE;
            else if (start) begin
               state_nxt = LOAD;
               clr       = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // count doubles as the write pointer: it only advances on legal writes and
   // is cleared at session start, so the next free address is count itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         wr_en <= accept && !enc.illegal;
         err   <= accept && enc.illegal;
         if (accept && !enc.illegal) begin
            wr_addr <= count[AW-1:0];
            wr_data <= enc.word;
         end
         if (clr) count <= '0;
         else if (accept && !enc.illegal) count <= count + (AW+1)'(1);
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed literal checks plus random traffic
// compared each cycle against a behavioural session/encoding model.
module tb_inst_encoder_loader;
   localparam int AW = 3;
   localparam int DEPTH = 4;

   logic clk, rst, start, finish, in_valid, in_ready;
   logic [4:0] cls, rs, rt, rd, shamt;
   logic [5:0] func;
   logic [15:0] imm;
   logic [25:0] target;
   logic wr_en, busy, full, err;
   logic [AW-1:0] wr_addr;
   logic [31:0] wr_data;
   logic [AW:0] count;

   inst_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .cls(cls), .func(func),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .full(full), .count(count), .err(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model ----
   bit [5:0] optab [32];
   int  m_st;      // 0 idle, 1 loading, 2 full
   int  m_n;
   bit  m_wr, m_err;
   int  m_addr;
   bit [31:0] m_data;

   function automatic bit [32:0] golden(input bit [4:0] c, input bit [5:0] fn,
         input bit [4:0] s, input bit [4:0] t, input bit [4:0] d,
         input bit [4:0] sh, input bit [15:0] im, input bit [25:0] tg);
      bit [4:0] sf, tf;
      if (c >= 23 || (c == 0 && fn == 6'd8)) return {1'b1, 32'd0};
      if (c == 0) return {1'b0, 6'd0, s, t, d, sh, fn};
      if (c == 1) return {1'b0, 6'd0, s, 15'd0, 6'd8};
      if (c == 21 || c == 22) return {1'b0, optab[c], tg};
      sf = (c == 2) ? 5'd0 : s;
      tf = (c == 17 || c == 20) ? 5'd0 : (c == 18) ? 5'd1 : t;
      return {1'b0, optab[c], sf, tf, im};
   endfunction

   always @(posedge clk) begin
      bit acc, ill;
      bit [31:0] w;
      int n0;
      if (rst) begin
         m_st = 0; m_n = 0; m_wr = 0; m_err = 0;
      end else begin
         n0 = m_n;
         acc = in_valid && m_st == 1 && !finish && n0 < DEPTH;
         m_wr = 0; m_err = 0;
         if (acc) begin
            {ill, w} = golden(cls, func, rs, rt, rd, shamt, imm, target);
            if (ill) m_err = 1;
            else begin
               m_wr = 1; m_addr = n0; m_data = w; m_n = n0 + 1;
            end
         end
         case (m_st)
            0: if (start) begin m_st = 1; m_n = 0; end
            1: if (finish) m_st = 0; else if (n0 == DEPTH) m_st = 2;
            default: if (finish) m_st = 0; else if (start) begin m_st = 1; m_n = 0; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(m_st == 1 && !finish && m_n < DEPTH));
         chk("busy", 32'(busy), 32'(m_st == 1));
         chk("full", 32'(full), 32'(m_n == DEPTH));
         chk("count", 32'(count), 32'(m_n));
         chk("wr_en", 32'(wr_en), 32'(m_wr));
         chk("err", 32'(err), 32'(m_err));
         if (m_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", wr_data, m_data);
         end
      end
   end

   // ---- stimulus ----
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input bit [4:0] c, input bit [5:0] fn, input bit [4:0] s,
         input bit [4:0] t, input bit [4:0] d, input bit [15:0] im, input bit [25:0] tg);
      in_valid = 1; cls = c; func = fn; rs = s; rt = t; rd = d; shamt = 0;
      imm = im; target = tg;
   endtask

   task automatic wr_expect(input string nm, input bit [31:0] a, input bit [31:0] d);
      @(negedge clk);
      chk({nm, ".wr_en"}, 32'(wr_en), 32'd1);
      chk({nm, ".addr"}, 32'(wr_addr), a);
      chk({nm, ".data"}, wr_data, d);
   endtask

   initial begin
      optab[0] = 6'b000000; optab[1] = 6'b000000;
      optab[2] = 6'b001111; optab[3] = 6'b001010; optab[4] = 6'b001101;
      optab[5] = 6'b001110; optab[6] = 6'b001000; optab[7] = 6'b001001;
      optab[8] = 6'b100011; optab[9] = 6'b101011; optab[10] = 6'b100001;
      optab[11] = 6'b100101; optab[12] = 6'b101001; optab[13] = 6'b100000;
      optab[14] = 6'b100100; optab[15] = 6'b101000; optab[16] = 6'b000100;
      optab[17] = 6'b000111; optab[18] = 6'b000001; optab[19] = 6'b000101;
      optab[20] = 6'b000110; optab[21] = 6'b000010; optab[22] = 6'b000011;
      for (int i = 23; i < 32; i++) optab[i] = 6'd0;

      rst = 1; start = 0; finish = 0; in_valid = 0;
      cls = 0; func = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; target = 0;
      tick(); tick();
      @(negedge clk);
      chk("rst.outs", {wr_en, busy, full, err, in_ready, 27'(count)}, 32'd0);
      rst = 0;
      chk_en = 1;

      // session 1: rtype, addi, lui, bgez then full
      start = 1; tick(); start = 0;
      req(0, 6'b100000, 1, 2, 3, 0, 0); tick();
      req(6, 0, 0, 8, 0, 16'd5, 0);
      wr_expect("rtype", 0, 32'h00221820);
      tick();
      req(2, 0, 7, 1, 0, 16'h1234, 0);
      wr_expect("addi", 1, 32'h20080005);
      chk("addi.count", 32'(count), 2);
      tick();
      req(18, 0, 3, 9, 0, 16'h0004, 0);
      wr_expect("lui", 2, 32'h3C011234);
      tick();
      req(6, 0, 1, 1, 0, 16'h7777, 0);
      wr_expect("bgez", 3, 32'h04610004);
      chk("full.flag", 32'(full), 1);
      chk("full.ready", 32'(in_ready), 0);
      tick();
      @(negedge clk);
      chk("full.held", 32'(wr_en), 0);
      chk("full.busy", 32'(busy), 0);
      in_valid = 0; finish = 1; tick(); finish = 0;
      @(negedge clk);
      chk("fin.busy", 32'(busy), 0);

      // session 2: jr/j back-to-back, illegal requests, finish collision
      start = 1; tick(); start = 0;
      req(1, 0, 31, 0, 0, 0, 0); tick();
      req(21, 0, 0, 0, 0, 0, 26'h0100000);
      wr_expect("jr", 0, 32'h03E00008);
      tick();
      req(25, 0, 1, 1, 1, 16'h1, 26'h1);
      wr_expect("j", 1, 32'h08100000);
      tick();
      req(0, 6'b001000, 1, 2, 3, 0, 0);
      @(negedge clk);
      chk("ill25.err", 32'(err), 1);
      chk("ill25.wr", 32'(wr_en), 0);
      chk("ill25.count", 32'(count), 2);
      tick();
      req(6, 0, 0, 8, 0, 16'd5, 0);
      @(negedge clk);
      chk("illjr.err", 32'(err), 1);
      chk("illjr.wr", 32'(wr_en), 0);
      tick();
      finish = 1;
      wr_expect("after_ill", 2, 32'h20080005);
      tick();
      finish = 0; in_valid = 0;
      @(negedge clk);
      chk("finvld.wr", 32'(wr_en), 0);
      chk("finvld.busy", 32'(busy), 0);
      chk("finvld.count", 32'(count), 3);

      // reset colliding with an accept drops the write
      start = 1; tick(); start = 0;
      req(6, 0, 0, 8, 0, 16'd5, 0); rst = 1; tick();
      rst = 0; in_valid = 0;
      @(negedge clk);
      chk("rstcol.outs", {wr_en, busy, full, err, in_ready, 27'(count)}, 32'd0);

      // random traffic
      for (int k = 0; k < 2000; k++) begin
         start = ($urandom_range(0, 7) == 0);
         finish = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 1);
         cls = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 22));
         func = ($urandom_range(0, 7) == 0) ? 6'b001000 : 6'($urandom);
         rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         shamt = 5'($urandom); imm = 16'($urandom); target = 26'($urandom);
         tick();
      end
      start = 0; finish = 0; in_valid = 0;
      tick(); tick();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
